// File: rtl/alu_md.sv
// Pipelined-issue ALU with iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops return in one cycle; mult/div run WIDTH iterations then retire.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ALUConf,
  input  logic             Sign,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             InValid,
  input  logic             Flush,
  output logic             InReady,
  output logic [WIDTH-1:0] Result,
  output logic             OutValid,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int DW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
    return ~v + DW'(1);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [DW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d, in1_q, in1_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, is_div_q, is_div_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             out_valid_q, out_valid_d;

  logic             accept_s, last_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, alu_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH:0]   sum_s, trial_s;
  logic [DW-1:0]    prod_s;

  assign accept_s = InValid && (state_q == IDLE) && !Flush;
  assign last_s   = (cnt_q == (SHW+1)'(WIDTH - 1));
  assign a_mag_s  = (Sign && In1[WIDTH-1]) ? neg_w(In1) : In1;
  assign b_mag_s  = (Sign && In2[WIDTH-1]) ? neg_w(In2) : In2;
  assign sh_s     = In1[SHW-1:0];
  assign sum_s    = {1'b0, p_q[DW-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign trial_s  = p_q[DW-1:WIDTH-1] - {1'b0, b_q};
  assign prod_s   = neg_q ? neg_dw(p_q) : p_q;

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      b_q         <= '0;
      in1_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      is_div_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      b_q         <= b_d;
      in1_q       <= in1_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      is_div_q    <= is_div_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && ALUConf == 5'b01010)      state_d = MUL;
        else if (accept_s && ALUConf == 5'b01011) state_d = DIV;
        else                                      state_d = IDLE;
      end
      MUL, DIV: begin
        if (Flush)       state_d = IDLE;
        else if (last_s) state_d = DONE;
        else             state_d = state_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ALU result.
  always_comb begin
    alu_s = '0;
    case (ALUConf)
      5'b00000: alu_s = In1 + In2;
      5'b00001: alu_s = In1 - In2;
      5'b00010: alu_s = In1 & In2;
      5'b00011: alu_s = In1 | In2;
      5'b00100: alu_s = In1 ^ In2;
      5'b00101: alu_s = ~(In1 | In2);
      5'b00110: alu_s = In2 << sh_s;
      5'b00111: alu_s = In2 >> sh_s;
      5'b01000: alu_s = $unsigned($signed(In2) >>> sh_s);
      5'b01001: alu_s = Sign ? {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))}
                             : {{(WIDTH-1){1'b0}}, (In1 < In2)};
      5'b01100: alu_s = hi_q;
      5'b01101: alu_s = lo_q;
      default:  alu_s = '0;
    endcase
  end

  // Datapath and output updates.
  always_comb begin
    cnt_d       = cnt_q;
    p_d         = p_q;
    b_d         = b_q;
    in1_d       = in1_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    is_div_d    = is_div_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (accept_s && (ALUConf == 5'b01010 || ALUConf == 5'b01011)) begin
          cnt_d    = '0;
          p_d      = {{WIDTH{1'b0}}, a_mag_s};
          b_d      = b_mag_s;
          in1_d    = In1;
          neg_d    = Sign && (In1[WIDTH-1] ^ In2[WIDTH-1]);
          rneg_d   = Sign && In1[WIDTH-1];
          dz_d     = (In2 == '0);
          is_div_d = (ALUConf == 5'b01011);
        end else if (accept_s) begin
          result_d    = alu_s;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      MUL: begin
        cnt_d = cnt_q + (SHW+1)'(1);
        p_d   = {sum_s, p_q[WIDTH-1:1]};
      end
      DIV: begin
        cnt_d = cnt_q + (SHW+1)'(1);
        // Restoring step: keep the trial remainder only when it did not go negative.
        if (!trial_s[WIDTH]) p_d = {trial_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        else                 p_d = {p_q[DW-2:0], 1'b0};
      end
      DONE: begin
        if (is_div_q && dz_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = in1_q;
        end else if (is_div_q) begin
          lo_d = neg_q  ? neg_w(p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
          hi_d = rneg_q ? neg_w(p_q[DW-1:WIDTH]) : p_q[DW-1:WIDTH];
        end else begin
          lo_d = prod_s[WIDTH-1:0];
          hi_d = prod_s[DW-1:WIDTH];
        end
        result_d    = lo_d;
        out_valid_d = 1'b1;
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  assign InReady  = (state_q == IDLE);
  assign Result   = result_q;
  assign OutValid = out_valid_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32.
module tb_alu_md;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  ALUConf;
  logic        Sign;
  logic [31:0] In1, In2;
  logic        InValid, Flush;
  logic        InReady, OutValid;
  logic [31:0] Result, Hi, Lo;

  int checks = 0;
  int errors = 0;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .ALUConf(ALUConf), .Sign(Sign),
    .In1(In1), .In2(In2), .InValid(InValid), .Flush(Flush),
    .InReady(InReady), .Result(Result), .OutValid(OutValid), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] op, input logic s, input logic [31:0] a, input logic [31:0] b);
    ALUConf = op; Sign = s; In1 = a; In2 = b; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!OutValid && n <= 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ALUConf = 5'd0; Sign = 1'b0; In1 = 32'd0; In2 = 32'd0;
    InValid = 1'b0; Flush = 1'b0;
    #12;
    checks++;
    if ({Result, Hi, Lo} !== 96'd0 || OutValid !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: Result=%h Hi=%h Lo=%h OutValid=%b InReady=%b, required all 0, InReady=1",
               Result, Hi, Lo, OutValid, InReady);
    end
    reset_n = 1'b1;
    drive(5'b00000, 1'b0, 32'd2, 32'd3);
    checks++;
    if (OutValid !== 1'b1 || Result !== 32'd5) begin
      errors++;
      $display("FAIL first_accept: OutValid=%b Result=%h, required 1 / 00000005", OutValid, Result);
    end
  endtask

  task automatic test_back_to_back;
    ALUConf = 5'b00000; Sign = 1'b0; In1 = 32'hFFFFFFFF; In2 = 32'd1; InValid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (OutValid !== 1'b1 || Result !== 32'h0) begin
      errors++;
      $display("FAIL b2b_add: OutValid=%b Result=%h, required 1 / 00000000", OutValid, Result);
    end
    ALUConf = 5'b01000; In1 = 32'd4; In2 = 32'h80000000;
    @(posedge clk); #1;
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || Result !== 32'hF8000000) begin
      errors++;
      $display("FAIL b2b_sra: OutValid=%b Result=%h, required 1 / f8000000", OutValid, Result);
    end
    @(posedge clk); #1;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: OutValid=%b, required 0", OutValid);
    end
  endtask

  task automatic test_alu_ops;
    logic [4:0]  op [11] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                             5'b00111, 5'b01001, 5'b01001, 5'b11111, 5'b00000};
    logic        sg [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] a  [11] = '{32'd0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0,
                             32'h00000024, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h12345678, 32'h7FFFFFFF};
    logic [31:0] b  [11] = '{32'd1, 32'h0FF00FF0, 32'h0F0F0F0F, 32'h0FF00FF0, 32'h0F0F0F0F,
                             32'h00000001, 32'h80000000, 32'd1, 32'd1, 32'h1, 32'h1};
    logic [31:0] ex [11] = '{32'hFFFFFFFF, 32'h00F000F0, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h00000000,
                             32'h00000010, 32'h08000000, 32'd1, 32'd0, 32'd0, 32'h80000000};
    for (int i = 0; i < 11; i++) begin
      drive(op[i], sg[i], a[i], b[i]);
      checks++;
      if (OutValid !== 1'b1 || Result !== ex[i]) begin
        errors++;
        $display("FAIL alu_op[%0d] conf=%b: OutValid=%b Result=%h, required 1 / %h",
                 i, op[i], OutValid, Result, ex[i]);
      end
    end
  endtask

  task automatic test_mult;
    int n = 0;
    logic ready_bad = 1'b0;
    drive(5'b01010, 1'b1, 32'hFFFFFFFD, 32'd7);
    while (!OutValid && n <= 40) begin
      if (InReady !== 1'b0) ready_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL mult_latency: cycles=%0d, required 33", n);
    end
    checks++;
    if (ready_bad) begin
      errors++;
      $display("FAIL mult_inready: InReady seen 1, required 0 while busy");
    end
    checks++;
    if (Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFEB || Result !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_signed: Hi=%h Lo=%h Result=%h, required ffffffff/ffffffeb/ffffffeb", Hi, Lo, Result);
    end
    drive(5'b01010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(n);
    checks++;
    if (n != 33 || Hi !== 32'hFFFFFFFE || Lo !== 32'h00000001) begin
      errors++;
      $display("FAIL mult_unsigned: cycles=%0d Hi=%h Lo=%h, required 33 fffffffe/00000001", n, Hi, Lo);
    end
  endtask

  task automatic test_div;
    int n;
    drive(5'b01011, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_out(n);
    checks++;
    if (n != 33 || Lo !== 32'hFFFFFFFD || Hi !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_signed: cycles=%0d Lo=%h Hi=%h, required 33 fffffffd/ffffffff", n, Lo, Hi);
    end
    drive(5'b01100, 1'b0, 32'd0, 32'd0);
    checks++;
    if (OutValid !== 1'b1 || Result !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL mfhi_after_div: OutValid=%b Result=%h, required 1 / ffffffff", OutValid, Result);
    end
    drive(5'b01011, 1'b0, 32'd100, 32'd7);
    wait_out(n);
    checks++;
    if (Lo !== 32'd14 || Hi !== 32'd2) begin
      errors++;
      $display("FAIL div_unsigned: Lo=%h Hi=%h, required 0000000e/00000002", Lo, Hi);
    end
  endtask

  task automatic test_div_special;
    int n;
    drive(5'b01011, 1'b0, 32'd5, 32'd0);
    wait_out(n);
    checks++;
    if (n != 33 || Hi !== 32'd5 || Lo !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_by_zero: cycles=%0d Hi=%h Lo=%h, required 33 00000005/ffffffff", n, Hi, Lo);
    end
    drive(5'b01011, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_out(n);
    checks++;
    if (n != 33 || Hi !== 32'd0 || Lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_min_neg1: cycles=%0d Hi=%h Lo=%h, required 33 00000000/80000000", n, Hi, Lo);
    end
  endtask

  task automatic test_flush;
    int n;
    logic seen = 1'b0;
    drive(5'b01010, 1'b0, 32'd6, 32'd7);
    wait_out(n);
    checks++;
    if (Lo !== 32'd42 || Hi !== 32'd0) begin
      errors++;
      $display("FAIL flush_setup: Hi=%h Lo=%h, required 00000000/0000002a", Hi, Lo);
    end
    drive(5'b01010, 1'b0, 32'h1234, 32'h10);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      if (OutValid) seen = 1'b1;
    end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: InReady=%b, required 1", InReady);
    end
    for (int i = 0; i < 40; i++) begin
      if (OutValid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || Lo !== 32'd42 || Hi !== 32'd0) begin
      errors++;
      $display("FAIL flush_no_out: OutValid seen=%b Hi=%h Lo=%h, required 0 00000000/0000002a", seen, Hi, Lo);
    end
    Flush = 1'b1;
    drive(5'b00000, 1'b0, 32'd1, 32'd1);
    Flush = 1'b0;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept: OutValid=%b, required 0", OutValid);
    end
    drive(5'b01101, 1'b0, 32'd0, 32'd0);
    checks++;
    if (OutValid !== 1'b1 || Result !== 32'd42) begin
      errors++;
      $display("FAIL mflo_after_flush: OutValid=%b Result=%h, required 1 / 0000002a", OutValid, Result);
    end
  endtask

  task automatic test_reset_mid_div;
    logic seen = 1'b0;
    drive(5'b01011, 1'b0, 32'd100, 32'd7);
    for (int i = 1; i < 15; i++) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({Result, Hi, Lo} !== 96'd0 || OutValid !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_div: Result=%h Hi=%h Lo=%h OutValid=%b InReady=%b, required all 0, InReady=1",
               Result, Hi, Lo, OutValid, InReady);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (OutValid) seen = 1'b1;
    end
    checks++;
    if (seen || {Result, Hi, Lo} !== 96'd0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_out: OutValid seen=%b Result=%h Hi=%h Lo=%h InReady=%b, required 0, all 0, 1",
               seen, Result, Hi, Lo, InReady);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alu_ops();
    test_mult();
    test_div();
    test_div_special();
    test_flush();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and set the data width; legal values are 8, 16, 32 and 64.
REQ-002 The parameter SHW SHALL default to $clog2(WIDTH) and set the number of shift-amount bits taken from In1.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, with all state updated on its rising edge.
REQ-004 Port reset_n SHALL be an input, 1 bit wide: the reset, which is asynchronous and active-low.
REQ-005 Port ALUConf SHALL be an input, 5 bits wide: the operation select.
REQ-006 Port Sign SHALL be an input, 1 bit wide: 1 selects signed and 0 selects unsigned for slt, mult and div.
REQ-007 Ports In1 and In2 SHALL be inputs, each WIDTH bits wide: the operands.
REQ-008 Port InValid SHALL be an input, 1 bit wide: the operation-request strobe.
REQ-009 Port Flush SHALL be an input, 1 bit wide: a synchronous abort of an in-flight mult or div.
REQ-010 Port InReady SHALL be an output, 1 bit wide: the block can accept a request.
REQ-011 Port Result SHALL be an output, WIDTH bits wide: the registered result.
REQ-012 Port OutValid SHALL be an output, 1 bit wide: a one-cycle pulse marking Result as valid.
REQ-013 Ports Hi and Lo SHALL be outputs, each WIDTH bits wide: the architectural HI and LO registers.

Function
REQ-014 Encodings SHALL be:
- 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 nor
- 00110 sll, 00111 srl, 01000 sra, 01001 slt
- 01010 mult, 01011 div, 01100 mfhi, 01101 mflo
REQ-015 A request SHALL be accepted on a rising edge where InValid=1, InReady=1 and Flush=0.
REQ-016 The FSM SHALL have the states IDLE, MUL, DIV and DONE, with InReady=1 only in IDLE.
REQ-017 Single-cycle ops (00000–01001, 01100, 01101) accepted in IDLE SHALL register Result and pulse OutValid on the next cycle (latency 1), with the FSM staying in IDLE to allow back-to-back issue.
REQ-018 add and sub SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-019 Shifts SHALL:
- shift In2 by In1[SHW-1:0]
- ignore the upper bits of In1
- make sra arithmetic
REQ-020 slt SHALL return 1 or 0, zero-extended, with a signed compare when Sign=1 and an unsigned compare when Sign=0.
REQ-021 mfhi and mflo SHALL return the current Hi and Lo.
REQ-022 An undefined ALUConf SHALL return Result=0 and still pulse OutValid.
REQ-023 Accepting mult SHALL latch the operands and enter MUL, and accepting div SHALL do the same and enter DIV.
REQ-024 MUL SHALL perform one shift-add iteration per cycle, and DIV SHALL perform one restoring-division step per cycle.
REQ-025 The iteration counter SHALL have SHW+1 bits; MUL and DIV SHALL run exactly WIDTH cycles and then enter DONE.
REQ-026 In DONE the block SHALL:
- write Hi and Lo
- drive Result=Lo
- pulse OutValid
- return to IDLE
REQ-027 mult and div latency from the accept edge to the OutValid cycle SHALL therefore be WIDTH+1 cycles.
REQ-028 mult SHALL produce the full 2*WIDTH-bit product, with {Hi,Lo}=In1*In2 under signed or unsigned interpretation per Sign.
REQ-029 div SHALL write Lo=quotient and Hi=remainder.
REQ-030 Signed div SHALL use magnitudes with sign fix-up:
- quotient truncated toward zero
- remainder taking the sign of the dividend
REQ-031 Divide by zero SHALL give Lo=all-ones and Hi=In1 with latency unchanged.
REQ-032 Signed MIN/-1 SHALL give Lo=MIN and Hi=0.
REQ-033 Flush=1 in MUL or DIV SHALL return the FSM to IDLE on the next edge with no OutValid and Hi/Lo unchanged.
REQ-034 Flush=1 in IDLE SHALL block acceptance that cycle.
REQ-035 Hi and Lo SHALL change only in DONE.
REQ-036 mfhi or mflo SHALL return values that include any immediately preceding completed mult or div.
REQ-037 InValid asserted while InReady=0 SHALL be ignored, with no queuing.

Reset
REQ-038 While reset_n=0 the block SHALL asynchronously force:
- the FSM to IDLE
- the counter to 0
- Result, Hi and Lo to 0
- OutValid to 0
- InReady to 1
REQ-039 Reset asserted mid-MUL or mid-DIV SHALL abort the operation with no OutValid afterwards.
REQ-040 On the first rising edge after reset_n deasserts, the block SHALL accept a request.

Verification (WIDTH=32)
REQ-041 The bench SHALL apply add 0xFFFFFFFF+1, then sra In1=4, In2=0x80000000 back-to-back, and check Result=0 then Result=0xF8000000 on consecutive cycles, each with OutValid.
REQ-042 The bench SHALL apply signed mult -3*7 and check that OutValid fires exactly 33 cycles after accept with Hi=0xFFFFFFFF and Lo=0xFFFFFFEB, and that InReady=0 throughout.
REQ-043 The bench SHALL apply signed div -7/2 followed by mfhi, and check Lo=0xFFFFFFFD, Hi=0xFFFFFFFF and mfhi Result=0xFFFFFFFF.
REQ-044 The bench SHALL apply unsigned div 5/0 and signed div 0x80000000/0xFFFFFFFF, and check {Hi,Lo}={5,0xFFFFFFFF} and {0,0x80000000} respectively.
REQ-045 The bench SHALL apply mult, then Flush at cycle 10, then mflo, and check that there is no OutValid for the mult and that mflo returns the prior Lo.
REQ-046 The bench SHALL apply div, pull reset_n low at cycle 15 and then release it, and check all outputs are 0 with InReady=1 and no OutValid.
